bk_bus_initiator: RTL and testbench
===================================

// Module: bk_bus_initiator
// PURPOSE
//  Bus-master end of the BK system-bus handshake (SYNC/DIN/DOUT/WTBT/RPLY).
//  Turns a single-request local port into one complete bus cycle, then waits for the addressed responder's RPLY.
//  Serves DMA-style clients (tape/floppy loaders, debug monitor) and drives the same bus the bkcore responder answers.
//  One transaction is outstanding at a time. There is no pipelining.
// PARAMETERS
//  SETUP_CYCLES  1   cycles ADDR_o/WTBT_o/DATA_o are held stable before SYNC_o rises (>=1)
//  TIMEOUT       64  ce-cycles without the expected RPLY edge before bus error (only with BK_BUS_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  p_reset    in   1   reset, asynchronous, active-high
//  ce         in   1   clock enable; FSM, counters and output pulses advance only when ce=1
//  req_i      in   1   start a transaction; sampled in IDLE only
//  we_i       in   1   1=write (DOUT cycle), 0=read (DIN cycle)
//  byte_i     in   1   byte access
//  addr_i     in   16  byte address
//  wdata_i    in   16  write data
//  busy_o     out  1   transaction in progress (not IDLE)
//  ack_o      out  1   one-ce-cycle pulse: transaction completed OK
//  err_o      out  1   one-ce-cycle pulse: odd-address trap or timeout
//  rdata_o    out  16  read data; valid from ack_o until next accepted req
//  SYNC_o     out  1   bus cycle framing
//  DIN_o      out  1   read strobe
//  DOUT_o     out  1   write strobe
//  WTBT_o     out  1   byte-op qualifier
//  ADDR_o     out  16  bus address
//  DATA_o     out  16  bus write data
//  RPLY_i     in   1   responder reply (synchronous to clk)
//  DATA_i     in   16  bus read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Reset asserted mid-cycle drops SYNC/DIN/DOUT immediately. No ack/err is issued.
//  States: IDLE -> SETUP -> ASSERT -> RELEASE -> IDLE. A fault goes to FAULT -> IDLE.
//  IDLE: busy_o=0. When req_i=1 and RPLY_i=0:
//    - Word access (byte_i=0) with addr_i[0]=1: go to FAULT. No bus activity.
//    - Otherwise latch the request, drive ADDR_o, WTBT_o=byte_i, and go to SETUP.
//    - DATA_o = byte_i&addr_i[0] ? {wdata_i[7:0],wdata_i[7:0]} : wdata_i (writes); reads drive 0.
//    - req_i while RPLY_i=1 (stale reply) is held off until RPLY_i=0.
//  SETUP: hold for SETUP_CYCLES ce-cycles, then go to ASSERT.
//  ASSERT: SYNC_o=1 with DOUT_o=we, DIN_o=~we. ADDR/WTBT/DATA remain stable.
//    - On the first ce-cycle with RPLY_i=1: rdata_o<=DATA_i (read only), deassert SYNC/DIN/DOUT next cycle, go to RELEASE.
//    - Minimum SYNC_o high time is 1 cycle.
//  RELEASE: wait for RPLY_i=0. Then pulse ack_o for 1 ce-cycle and go to IDLE. Outputs ADDR/WTBT/DATA clear to 0.
//  Latency with an immediate responder and SETUP_CYCLES=1: req to SYNC rise = 2 cycles; RPLY rise to ack_o = 2 cycles.
//  FAULT: err_o=1 for one ce-cycle, bus strobes 0, then IDLE. rdata_o is unchanged.
//  req_i while busy_o=1 is ignored (no queueing).
//  ce=0 freezes the FSM and timeout counter and holds all outputs.
// CONFIGURATION
//  BK_BUS_TIMEOUT_EN defined:
//    - Counter cleared on each state entry. Counts ce-cycles spent in ASSERT (waiting for RPLY=1) or RELEASE (waiting for RPLY=0).
//    - Reaching TIMEOUT: drop all strobes and go to FAULT (err_o pulse). In ASSERT, rdata_o is not updated.
//  BK_BUS_TIMEOUT_EN undefined: no counter. Waits forever. err_o is only raised by the odd-address trap.
// STRUCTURE
//  Shared package bk_bus_pkg:
//    - FSM state typedef/localparams (IDLE, SETUP, ASSERT, RELEASE, FAULT).
//    - Bus width constants (BUS_AW=16, BUS_DW=16).
//    - Odd-byte lane-replication function, shared with bkcore write path.
//  Sub-module bk_bus_watchdog (clear, run, ce -> expired):
//    - Instantiated only under BK_BUS_TIMEOUT_EN.
//    - Counter width $clog2(TIMEOUT+1).
//  Everything else is in this file.
// TESTING
//  1 Word write addr 'o040000 data 'o123456, responder RPLY 3 cycles after SYNC:
//    -> DOUT_o=1 & SYNC_o=1, DATA_o='o123456, WTBT_o=0, one ack_o, DIN_o never 1.
//  2 Byte write addr 'o040001 wdata 16'h00A5:
//    -> DATA_o=16'hA5A5, WTBT_o=1, ack_o after RPLY fall.
//  3 Word read addr 'o100000, responder returns 16'h1234 with RPLY:
//    -> DIN_o=1, rdata_o=16'h1234 at ack_o. Second req held off until RPLY low.
//  4 Word read at odd addr 'o000003
//    -> err_o pulse 1 cycle after req, SYNC_o never asserted, rdata_o unchanged.
//  5 BK_BUS_TIMEOUT_EN, TIMEOUT=8, responder silent
//    -> SYNC_o drops and err_o pulses 8 ce-cycles after SYNC rise. Next req proceeds normally.
//  6 p_reset asserted while in ASSERT:
//    -> SYNC/DIN/DOUT/busy_o 0 same cycle, no ack_o/err_o. ce toggling stretches timing proportionally.

Source files
------------

// File: rtl/bk_bus_pkg.sv
// Shared BK system-bus definitions: FSM states, bus widths and the odd-byte
// write-lane replication used by both the initiator and the bkcore write path.
package bk_bus_pkg;

  localparam int BUS_AW = 16;
  localparam int BUS_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ASSERT,
    ST_RELEASE,
    ST_FAULT
  } bus_state_e;

  // An odd-address byte write lands on the high lane, so the low byte is mirrored there.
  function automatic logic [BUS_DW-1:0] bus_lane_data(
    input logic              byte_op,
    input logic              odd_addr,
    input logic [BUS_DW-1:0] wdata
  );
    return (byte_op && odd_addr) ? {wdata[7:0], wdata[7:0]} : wdata;
  endfunction

endpackage

// File: rtl/bk_bus_initiator_if.sv
// BK system-bus signal bundle: the master drives SYNC/DIN/DOUT/WTBT/ADDR/DATA,
// the addressed responder returns RPLY and read data.
interface bk_bus_initiator_if;
  import bk_bus_pkg::*;

  logic              SYNC_o;
  logic              DIN_o;
  logic              DOUT_o;
  logic              WTBT_o;
  logic [BUS_AW-1:0] ADDR_o;
  logic [BUS_DW-1:0] DATA_o;
  logic              RPLY_i;
  logic [BUS_DW-1:0] DATA_i;

  modport master (
    output SYNC_o, DIN_o, DOUT_o, WTBT_o, ADDR_o, DATA_o,
    input  RPLY_i, DATA_i
  );

  modport slave (
    input  SYNC_o, DIN_o, DOUT_o, WTBT_o, ADDR_o, DATA_o,
    output RPLY_i, DATA_i
  );

endinterface

// File: rtl/bk_bus_watchdog.sv
// Reply watchdog for the BK bus initiator; only present when BK_BUS_TIMEOUT_EN
// is defined. Fires on the ce-cycle that completes TIMEOUT cycles of waiting.
`ifdef BK_BUS_TIMEOUT_EN
module bk_bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic p_reset,
  input  logic ce,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturating count of ce-cycles spent waiting; clear wins so each state starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      if (clear_i) begin
        cnt_d = '0;
      end else if (run_i && (cnt_q != CW'(TIMEOUT))) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign expired_o = ce && run_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/bk_bus_initiator.sv
// BK system-bus master: turns one local request into a SYNC/DIN/DOUT cycle and waits for RPLY.
// Optional reply timeout (bus error) is built when BK_BUS_TIMEOUT_EN is defined.
module bk_bus_initiator
  import bk_bus_pkg::*;
#(
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              p_reset,
  input  logic              ce,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              byte_i,
  input  logic [BUS_AW-1:0] addr_i,
  input  logic [BUS_DW-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [BUS_DW-1:0] rdata_o,
  bk_bus_initiator_if.master bus
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [SCW-1:0] SETUP_LAST = SCW'(SETUP_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("bk_bus_initiator: SETUP_CYCLES must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("bk_bus_initiator: TIMEOUT must be at least 1");
  end

  bus_state_e        state_q, state_d;
  logic [SCW-1:0]    setup_cnt_q, setup_cnt_d;
  logic              we_q, we_d;
  logic              sync_q, sync_d;
  logic              din_q, din_d;
  logic              dout_q, dout_d;
  logic              wtbt_q, wtbt_d;
  logic [BUS_AW-1:0] addr_q, addr_d;
  logic [BUS_DW-1:0] data_q, data_d;
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              timeout_expired;

  // Everything holds while ce=0; a stale RPLY from a previous cycle blocks a new start.
  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    we_d        = we_q;
    sync_d      = sync_q;
    din_d       = din_q;
    dout_d      = dout_q;
    wtbt_d      = wtbt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;

    if (ce) begin
      ack_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_i && !bus.RPLY_i) begin
            if (!byte_i && addr_i[0]) begin
              state_d = ST_FAULT;
            end else begin
              state_d     = ST_SETUP;
              setup_cnt_d = '0;
              we_d        = we_i;
              wtbt_d      = byte_i;
              addr_d      = addr_i;
              data_d      = we_i ? bus_lane_data(byte_i, addr_i[0], wdata_i) : '0;
            end
          end
        end

        ST_SETUP: begin
          if (setup_cnt_q == SETUP_LAST) begin
            state_d = ST_ASSERT;
            sync_d  = 1'b1;
            dout_d  = we_q;
            din_d   = !we_q;
          end else begin
            setup_cnt_d = setup_cnt_q + SCW'(1);
          end
        end

        ST_ASSERT: begin
          if (bus.RPLY_i) begin
            if (!we_q) begin
              rdata_d = bus.DATA_i;
            end
            sync_d  = 1'b0;
            din_d   = 1'b0;
            dout_d  = 1'b0;
            state_d = ST_RELEASE;
          end else if (timeout_expired) begin
            sync_d  = 1'b0;
            din_d   = 1'b0;
            dout_d  = 1'b0;
            wtbt_d  = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            state_d = ST_FAULT;
          end
        end

        ST_RELEASE: begin
          if (!bus.RPLY_i) begin
            ack_d   = 1'b1;
            wtbt_d  = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            state_d = ST_IDLE;
          end else if (timeout_expired) begin
            wtbt_d  = 1'b0;
            addr_d  = '0;
            data_d  = '0;
            state_d = ST_FAULT;
          end
        end

        ST_FAULT: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge p_reset) begin
    if (p_reset) begin
      state_q     <= ST_IDLE;
      setup_cnt_q <= '0;
      we_q        <= 1'b0;
      sync_q      <= 1'b0;
      din_q       <= 1'b0;
      dout_q      <= 1'b0;
      wtbt_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      we_q        <= we_d;
      sync_q      <= sync_d;
      din_q       <= din_d;
      dout_q      <= dout_d;
      wtbt_q      <= wtbt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
    end
  end

`ifdef BK_BUS_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  // Restart the count on every state change so ASSERT and RELEASE are timed separately.
  assign wd_clear = ce && (state_d != state_q);
  assign wd_run   = (state_q == ST_ASSERT) || (state_q == ST_RELEASE);

  bk_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .p_reset   (p_reset),
    .ce        (ce),
    .clear_i   (wd_clear),
    .run_i     (wd_run),
    .expired_o (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = (state_q == ST_FAULT);
  assign ack_o      = ack_q;
  assign rdata_o    = rdata_q;

  assign bus.SYNC_o = sync_q;
  assign bus.DIN_o  = din_q;
  assign bus.DOUT_o = dout_q;
  assign bus.WTBT_o = wtbt_q;
  assign bus.ADDR_o = addr_q;
  assign bus.DATA_o = data_q;

endmodule

// File: tb/tb_bk_bus_initiator.sv
// Directed bench for bk_bus_initiator: a scripted responder answers bus cycles and a
// scoreboard queue holds the expected completion of every request issued.
module tb_bk_bus_initiator;

  logic        clk = 1'b0;
  logic        p_reset;
  logic        ce;
  logic        req_i;
  logic        we_i;
  logic        byte_i;
  logic [15:0] addr_i;
  logic [15:0] wdata_i;
  logic        busy_o;
  logic        ack_o;
  logic        err_o;
  logic [15:0] rdata_o;

  logic        resp_rply;
  logic        stale_rply;
  logic        resp_silent;
  logic        ce_toggle;
  int          resp_delay;
  int          resp_cnt;
  logic [15:0] resp_data;

  typedef struct {
    logic        is_err;
    logic        chk_rdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb_q[$];

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int n_ack     = 0;
  int n_err     = 0;
  int n_ack_hi  = 0;
  int n_din     = 0;
  int n_dout    = 0;
  int n_sync    = 0;

  always #5 clk = ~clk;

  bk_bus_initiator_if bus_if ();

  assign bus_if.RPLY_i = resp_rply | stale_rply;
  assign bus_if.DATA_i = resp_data;

  bk_bus_initiator #(
    .SETUP_CYCLES (1),
    .TIMEOUT      (8)
  ) u_dut (
    .clk     (clk),
    .p_reset (p_reset),
    .ce      (ce),
    .req_i   (req_i),
    .we_i    (we_i),
    .byte_i  (byte_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy_o  (busy_o),
    .ack_o   (ack_o),
    .err_o   (err_o),
    .rdata_o (rdata_o),
    .bus     (bus_if)
  );

  // Clock enable: steady 1, or alternating every clock when ce_toggle is set.
  initial begin
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ce = ce_toggle ? ~ce : 1'b1;
    end
  end

  // Responder: raises RPLY resp_delay clocks into SYNC (unless silent), drops it once SYNC falls.
  initial begin
    resp_rply = 1'b0;
    resp_cnt  = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus_if.SYNC_o) begin
        resp_rply = 1'b0;
        resp_cnt  = 0;
      end else begin
        resp_cnt++;
        if (!resp_silent && resp_cnt >= resp_delay) resp_rply = 1'b1;
      end
    end
  end

  // Event counters; pulses are counted once, on the enabled clock that ends them.
  always @(negedge clk) begin
    if (ack_o && ce) n_ack++;
    if (err_o && ce) n_err++;
    if (ack_o) n_ack_hi++;
    if (bus_if.DIN_o) n_din++;
    if (bus_if.DOUT_o) n_dout++;
    if (bus_if.SYNC_o) n_sync++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pushExpect(input logic is_err, input logic [15:0] rdata, input logic chk_rd);
    exp_t e;
    e.is_err    = is_err;
    e.chk_rdata = chk_rd;
    e.rdata     = rdata;
    sb_q.push_back(e);
  endtask

  // Records the expected outcome, then holds req_i until the initiator leaves IDLE.
  task automatic applyStimulus(input string tag, input logic we, input logic byt,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic exp_err, input logic [15:0] exp_rdata,
                               input logic chk_rd);
    logic got;
    pushExpect(exp_err, exp_rdata, chk_rd);
    req_i   = 1'b1;
    we_i    = we;
    byte_i  = byt;
    addr_i  = addr;
    wdata_i = wdata;
    for (int i = 0; i < 40 && !busy_o; i++) tick();
    got   = busy_o;
    req_i = 1'b0;
    checkOutput({tag, "_accept"}, got, 1);
  endtask

  // Waits (bounded) for ack_o or err_o and compares against the oldest expectation.
  task automatic checkCompletion(input string tag, input int max_cycles);
    logic done;
    exp_t e;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (ack_o || err_o) done = 1'b1;
      else tick();
    end
    if (!done && (ack_o || err_o)) done = 1'b1;
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_sb_entry"}, (sb_q.size() > 0), 1);
    if (done && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput({tag, "_err"}, err_o, e.is_err);
      checkOutput({tag, "_ack"}, ack_o, !e.is_err);
      if (e.chk_rdata) checkOutput({tag, "_rdata"}, rdata_o, e.rdata);
    end else if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end
  endtask

  int a0, e0, d0, s0, h0, o0;

  initial begin
    p_reset     = 1'b1;
    req_i       = 1'b0;
    we_i        = 1'b0;
    byte_i      = 1'b0;
    addr_i      = '0;
    wdata_i     = '0;
    stale_rply  = 1'b0;
    resp_silent = 1'b0;
    resp_delay  = 1;
    resp_data   = '0;
    ce_toggle   = 1'b0;

    repeat (3) tick();
    checkOutput("rst_flags", {ack_o, err_o, busy_o, bus_if.SYNC_o, bus_if.DIN_o,
                              bus_if.DOUT_o, bus_if.WTBT_o}, 0);
    checkOutput("rst_addr_data", {bus_if.ADDR_o, bus_if.DATA_o}, 0);
    checkOutput("rst_rdata", rdata_o, 0);
    p_reset = 1'b0;
    repeat (2) tick();

    $display("[TB] word write, responder 3 cycles after SYNC");
    resp_delay = 3;
    a0 = n_ack;
    d0 = n_din;
    applyStimulus("wr_word", 1'b1, 1'b0, 16'o040000, 16'o123456, 1'b0, 16'h0, 1'b0);
    checkOutput("wr_word_addr", bus_if.ADDR_o, 16'o040000);
    checkOutput("wr_word_data", bus_if.DATA_o, 16'o123456);
    checkOutput("wr_word_wtbt", bus_if.WTBT_o, 0);
    checkOutput("wr_word_sync_setup", bus_if.SYNC_o, 0);
    tick();
    checkOutput("wr_word_strobes", {bus_if.SYNC_o, bus_if.DOUT_o, bus_if.DIN_o}, 3'b110);
    checkCompletion("wr_word", 40);
    tick();
    checkOutput("wr_word_ack_count", n_ack - a0, 1);
    checkOutput("wr_word_din_never", n_din - d0, 0);
    checkOutput("wr_word_addr_clear", {bus_if.ADDR_o, bus_if.DATA_o}, 0);

    $display("[TB] byte writes, odd and even lane");
    resp_delay = 1;
    applyStimulus("wr_byte_odd", 1'b1, 1'b1, 16'o040001, 16'h00A5, 1'b0, 16'h0, 1'b0);
    checkOutput("wr_byte_odd_data", bus_if.DATA_o, 16'hA5A5);
    checkOutput("wr_byte_odd_wtbt", bus_if.WTBT_o, 1);
    checkCompletion("wr_byte_odd", 40);
    checkOutput("wr_byte_odd_rply_low", bus_if.RPLY_i, 0);
    tick();
    applyStimulus("wr_byte_even", 1'b1, 1'b1, 16'o040002, 16'h12A5, 1'b0, 16'h0, 1'b0);
    checkOutput("wr_byte_even_data", bus_if.DATA_o, 16'h12A5);
    checkCompletion("wr_byte_even", 40);
    tick();

    $display("[TB] word read, then stale reply hold-off");
    resp_data  = 16'h1234;
    resp_delay = 2;
    o0 = n_dout;
    applyStimulus("rd_word", 1'b0, 1'b0, 16'o100000, 16'hFFFF, 1'b0, 16'h1234, 1'b1);
    checkOutput("rd_word_data_o", bus_if.DATA_o, 0);
    tick();
    checkOutput("rd_word_strobes", {bus_if.SYNC_o, bus_if.DOUT_o, bus_if.DIN_o}, 3'b101);
    checkCompletion("rd_word", 40);
    tick();
    checkOutput("rd_word_dout_never", n_dout - o0, 0);

    stale_rply = 1'b1;
    s0 = n_sync;
    pushExpect(1'b0, 16'h5678, 1'b1);
    req_i  = 1'b1;
    we_i   = 1'b0;
    byte_i = 1'b0;
    addr_i = 16'o100002;
    repeat (3) tick();
    checkOutput("stale_busy", busy_o, 0);
    checkOutput("stale_sync", n_sync - s0, 0);
    checkOutput("stale_rdata_hold", rdata_o, 16'h1234);
    resp_data  = 16'h5678;
    stale_rply = 1'b0;
    tick();
    checkOutput("stale_release_busy", busy_o, 1);
    req_i = 1'b0;
    checkCompletion("rd_after_stale", 40);
    tick();

    $display("[TB] odd word read trap, legal odd byte read");
    e0 = n_err;
    s0 = n_sync;
    applyStimulus("odd_word", 1'b0, 1'b0, 16'o000003, 16'h0, 1'b1, 16'h5678, 1'b1);
    checkOutput("odd_word_err_now", err_o, 1);
    checkCompletion("odd_word", 5);
    tick();
    checkOutput("odd_word_pulse_end", {err_o, busy_o}, 0);
    checkOutput("odd_word_err_count", n_err - e0, 1);
    checkOutput("odd_word_no_sync", n_sync - s0, 0);
    resp_data = 16'hBEEF;
    applyStimulus("rd_byte_odd", 1'b0, 1'b1, 16'o000003, 16'h0, 1'b0, 16'hBEEF, 1'b1);
    checkOutput("rd_byte_odd_bus", {bus_if.WTBT_o, bus_if.ADDR_o}, {1'b1, 16'o000003});
    checkCompletion("rd_byte_odd", 40);
    tick();

`ifdef BK_BUS_TIMEOUT_EN
    $display("[TB] timeout in ASSERT and in RELEASE");
    resp_silent = 1'b1;
    applyStimulus("to_assert", 1'b1, 1'b0, 16'h2000, 16'h5555, 1'b1, 16'hBEEF, 1'b1);
    tick();
    checkOutput("to_assert_sync_rise", bus_if.SYNC_o, 1);
    repeat (7) tick();
    checkOutput("to_assert_held", {bus_if.SYNC_o, err_o}, 2'b10);
    tick();
    checkOutput("to_assert_drop", {bus_if.SYNC_o, err_o}, 2'b01);
    checkCompletion("to_assert", 2);
    resp_silent = 1'b0;
    tick();
    applyStimulus("to_recover", 1'b1, 1'b0, 16'h2002, 16'h6666, 1'b0, 16'h0, 1'b0);
    checkCompletion("to_recover", 40);
    tick();
    resp_silent = 1'b1;
    resp_data   = 16'hC0DE;
    applyStimulus("to_release", 1'b0, 1'b0, 16'h2004, 16'h0, 1'b1, 16'hC0DE, 1'b1);
    tick();
    stale_rply = 1'b1;
    checkCompletion("to_release", 30);
    stale_rply  = 1'b0;
    resp_silent = 1'b0;
    tick();
`endif

    $display("[TB] clock enable toggling");
    ce_toggle  = 1'b1;
    resp_delay = 1;
    h0 = n_ack_hi;
    a0 = n_ack;
    applyStimulus("ce_wr", 1'b1, 1'b0, 16'h1000, 16'h0F0F, 1'b0, 16'h0, 1'b0);
    checkCompletion("ce_wr", 80);
    repeat (4) tick();
    checkOutput("ce_ack_width", n_ack_hi - h0, 2);
    checkOutput("ce_ack_count", n_ack - a0, 1);
    ce_toggle = 1'b0;
    repeat (2) tick();

    $display("[TB] reset while SYNC is asserted");
    resp_silent = 1'b1;
    a0 = n_ack;
    e0 = n_err;
    applyStimulus("rst_mid", 1'b1, 1'b0, 16'h3000, 16'h1111, 1'b0, 16'h0, 1'b0);
    tick();
    checkOutput("rst_mid_in_assert", bus_if.SYNC_o & bus_if.DOUT_o, 1);
    #3;
    p_reset = 1'b1;
    #1;
    checkOutput("rst_mid_strobes", {bus_if.SYNC_o, bus_if.DIN_o, bus_if.DOUT_o, busy_o}, 0);
    sb_q.delete();
    repeat (2) tick();
    p_reset     = 1'b0;
    resp_silent = 1'b0;
    repeat (2) tick();
    checkOutput("rst_mid_no_ack_err", (n_ack - a0) + (n_err - e0), 0);
    checkOutput("rst_mid_rdata", rdata_o, 0);
    resp_data = 16'h0F0F;
    applyStimulus("post_rst_rd", 1'b0, 1'b0, 16'h4444, 16'h0, 1'b0, 16'h0F0F, 1'b1);
    checkCompletion("post_rst_rd", 40);
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
